// File: rtl/add12u_err_monitor.sv
// Error-metric monitor for an approximate W-bit unsigned adder: accumulates sum|err|, worst case and error count.
// Optional macro ADD12U_ERRMON_MSE_EN adds a sum-of-squared-error output with one extra cycle of latency.
module add12u_err_monitor #(
    parameter int W         = 12,
    parameter int CNT_W     = 20,
    parameter int N_SAMPLES = 4096,
    parameter int ACC_W     = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic [W-1:0]            in_b,
    input  logic [W:0]              in_o,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        sum_abs_err,
    output logic [W:0]              max_err,
    output logic [W-1:0]            max_a,
    output logic [W-1:0]            max_b,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        sample_count
`ifdef ADD12U_ERRMON_MSE_EN
    ,
    output logic [CNT_W+2*W+1:0]    sum_sq_err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_SAMPLES);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_sample_count;

    // Capture stage: operands held exactly as accepted
    logic             r_v0;
    logic [W-1:0]     r_a0;
    logic [W-1:0]     r_b0;
    logic [W:0]       r_o0;

    // S1: absolute difference against the exact sum
    logic             r_v1;
    logic [W-1:0]     r_a1;
    logic [W-1:0]     r_b1;
    logic [W:0]       r_diff1;

    // S2: run metrics
    logic [ACC_W-1:0] r_sum_abs_err;
    logic [W:0]       r_max_err;
    logic [W-1:0]     r_max_a;
    logic [W-1:0]     r_max_b;
    logic [CNT_W-1:0] r_err_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_clear;
    logic             w_drain_done;
    logic [W:0]       w_exact;
    logic [W:0]       w_diff;

    assign w_in_ready = (r_state == ST_RUN) && (r_sample_count < N_LIM);
    assign w_accept   = in_valid && w_in_ready;
    assign w_clear    = start && (r_state != ST_RUN);

    // Exact sum is W+1 bits wide so it never wraps; subtract smaller from larger
    assign w_exact = {1'b0, r_a0} + {1'b0, r_b0};
    assign w_diff  = (r_o0 >= w_exact) ? (r_o0 - w_exact) : (w_exact - r_o0);

`ifdef ADD12U_ERRMON_MSE_EN
    logic                    r_v2;
    logic [2*W+1:0]          r_sq2;
    logic [CNT_W+2*W+1:0]    r_sum_sq_err;

    // The final metric stage is S3 here, so S1 must also be empty before DONE
    assign w_drain_done = (r_sample_count == N_LIM) && !r_v0 && !r_v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2         <= 1'b0;
            r_sq2        <= '0;
            r_sum_sq_err <= '0;
        end else begin
            r_v2  <= r_v1;
            r_sq2 <= (2*W+2)'(r_diff1) * (2*W+2)'(r_diff1);
            if (w_clear) begin
                r_sum_sq_err <= '0;
            end else if (r_v2) begin
                r_sum_sq_err <= r_sum_sq_err + (CNT_W+2*W+2)'(r_sq2);
            end
        end
    end

    assign sum_sq_err = r_sum_sq_err;
`else
    // DONE is entered on the same edge the last sample commits in S2
    assign w_drain_done = (r_sample_count == N_LIM) && !r_v0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sample_count <= '0;
            r_v0           <= 1'b0;
            r_a0           <= '0;
            r_b0           <= '0;
            r_o0           <= '0;
            r_v1           <= 1'b0;
            r_a1           <= '0;
            r_b1           <= '0;
            r_diff1        <= '0;
            r_sum_abs_err  <= '0;
            r_max_err      <= '0;
            r_max_a        <= '0;
            r_max_b        <= '0;
            r_err_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start)        r_state <= ST_RUN;
                ST_RUN:  if (w_drain_done) r_state <= ST_DONE;
                ST_DONE: if (start)        r_state <= ST_RUN;
                default:                   r_state <= ST_IDLE;
            endcase

            if (w_clear) begin
                r_sample_count <= '0;
            end else if (w_accept) begin
                r_sample_count <= r_sample_count + CNT_W'(1);
            end

            r_v0 <= w_accept;
            if (w_accept) begin
                r_a0 <= in_a;
                r_b0 <= in_b;
                r_o0 <= in_o;
            end

            r_v1 <= r_v0;
            if (r_v0) begin
                r_a1    <= r_a0;
                r_b1    <= r_b0;
                r_diff1 <= w_diff;
            end

            if (w_clear) begin
                r_sum_abs_err <= '0;
                r_max_err     <= '0;
                r_max_a       <= '0;
                r_max_b       <= '0;
                r_err_count   <= '0;
            end else if (r_v1) begin
                r_sum_abs_err <= r_sum_abs_err + ACC_W'(r_diff1);
                if (r_diff1 != '0) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                // Strict compare keeps the operands of the first sample that hit the maximum
                if (r_diff1 > r_max_err) begin
                    r_max_err <= r_diff1;
                    r_max_a   <= r_a1;
                    r_max_b   <= r_b1;
                end
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = (r_state == ST_RUN);
    assign done         = (r_state == ST_DONE);
    assign sum_abs_err  = r_sum_abs_err;
    assign max_err      = r_max_err;
    assign max_a        = r_max_a;
    assign max_b        = r_max_b;
    assign err_count    = r_err_count;
    assign sample_count = r_sample_count;

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Scoreboard bench for add12u_err_monitor: randomized runs checked against a plain-arithmetic error model.
module tb_add12u_err_monitor;

    localparam int W     = 12;
    localparam int CNT_W = 20;
    localparam int ACC_W = 33;
    localparam int N     = 16;
    localparam int NB    = 4096;
`ifdef ADD12U_ERRMON_MSE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, start_big, in_valid;
    logic [W-1:0]     in_a, in_b;
    logic [W:0]       in_o;

    logic             in_ready, busy, done;
    logic [ACC_W-1:0] sum_abs_err;
    logic [W:0]       max_err;
    logic [W-1:0]     max_a, max_b;
    logic [CNT_W-1:0] err_count, sample_count;

    logic             in_ready_big, busy_big, done_big;
    logic [ACC_W-1:0] sum_abs_err_big;
    logic [W:0]       max_err_big;
    logic [W-1:0]     max_a_big, max_b_big;
    logic [CNT_W-1:0] err_count_big, sample_count_big;
`ifdef ADD12U_ERRMON_MSE_EN
    logic [CNT_W+2*W+1:0] sum_sq_err, sum_sq_err_big;
`endif

    add12u_err_monitor #(.W(W), .CNT_W(CNT_W), .N_SAMPLES(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy), .done(done),
        .sum_abs_err(sum_abs_err), .max_err(max_err), .max_a(max_a), .max_b(max_b),
        .err_count(err_count), .sample_count(sample_count)
`ifdef ADD12U_ERRMON_MSE_EN
        , .sum_sq_err(sum_sq_err)
`endif
    );

    add12u_err_monitor #(.W(W), .CNT_W(CNT_W), .N_SAMPLES(NB), .ACC_W(ACC_W)) dut_big (
        .clk(clk), .rst(rst), .start(start_big), .in_valid(in_valid), .in_ready(in_ready_big),
        .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy_big), .done(done_big),
        .sum_abs_err(sum_abs_err_big), .max_err(max_err_big), .max_a(max_a_big), .max_b(max_b_big),
        .err_count(err_count_big), .sample_count(sample_count_big)
`ifdef ADD12U_ERRMON_MSE_EN
        , .sum_sq_err(sum_sq_err_big)
`endif
    );

    typedef struct {
        longint sum;
        longint sq;
        int     maxe;
        int     maxa;
        int     maxb;
        int     errc;
        int     scnt;
        int     done_cyc;
    } exp_t;

    exp_t sb[$];
    int   q_a[$], q_b[$], q_o[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact sum in plain integers, absolute error, first strict maximum wins
    function automatic exp_t model_run();
        exp_t e;
        e = '{default: 0};
        for (int i = 0; i < q_a.size(); i++) begin
            int ex;
            int d;
            ex = q_a[i] + q_b[i];
            d  = (q_o[i] > ex) ? q_o[i] - ex : ex - q_o[i];
            e.sum += d;
            e.sq  += longint'(d) * longint'(d);
            if (d != 0) e.errc++;
            if (d > e.maxe) begin
                e.maxe = d;
                e.maxa = q_a[i];
                e.maxb = q_b[i];
            end
        end
        e.scnt = q_a.size();
        return e;
    endfunction

    function automatic int gen_o(input int a, input int b, input int d);
        int ex;
        ex = a + b;
        return (ex + d <= 8191) ? ex + d : ex - d;
    endfunction

    task automatic add_sample(input int a, input int b, input int o);
        q_a.push_back(a);
        q_b.push_back(b);
        q_o.push_back(o);
    endtask

    task automatic add_diff(input int d);
        int a, b;
        a = int'($urandom_range(4095));
        b = int'($urandom_range(4095));
        add_sample(a, b, gen_o(a, b, d));
    endtask

    task automatic add_random();
        int a, b, mode;
        a    = int'($urandom_range(4095));
        b    = int'($urandom_range(4095));
        mode = int'($urandom_range(3));
        case (mode)
            0:       add_sample(a, b, a + b);
            1:       add_sample(a, b, gen_o(a, b, int'($urandom_range(15))));
            2:       add_sample(a, b, int'($urandom_range(8191)));
            default: add_sample(a, b, gen_o(a, b, int'($urandom_range(2047))));
        endcase
    endtask

    task automatic clear_q();
        q_a.delete();
        q_b.delete();
        q_o.delete();
    endtask

    // Starts a run, streams the queued samples, pushes the expected result, waits for done
    task automatic drive_run(input int gap_pct, input bit poke_start);
        exp_t e;
        int   i, guard, last_acc, start_cyc, t;
        bit   acc;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
        chk("start_busy", busy, 1);
        chk("start_done_low", done, 0);
        chk("start_count_clr", sample_count, 0);
        chk("start_sum_clr", sum_abs_err, 0);
        i = 0; guard = 0; last_acc = 0;
        while (i < q_a.size() && guard < 400) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_a = W'($urandom); in_b = W'($urandom); in_o = (W+1)'($urandom);
            end else begin
                in_valid = 1'b1;
                in_a = W'(q_a[i]); in_b = W'(q_b[i]); in_o = (W+1)'(q_o[i]);
            end
            start = poke_start && (i == 5);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                last_acc = cyc;
            end
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("all_samples_accepted", i, q_a.size());
        e = model_run();
        e.done_cyc = (gap_pct == 0) ? start_cyc + N + LAT : last_acc + LAT;
        sb.push_back(e);
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout_pending", sb.size(), 0);
        sb.delete();
        chk("post_busy", busy, 0);
        chk("post_ready", in_ready, 0);
        // Offer samples while not ready: nothing must change
        in_valid = 1'b1;
        repeat (3) begin
            in_a = W'($urandom); in_b = W'($urandom); in_o = (W+1)'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("hold_done", done, 1);
        chk("hold_count", sample_count, N);
        chk("hold_sum", sum_abs_err, e.sum);
    endtask

    // Monitor: pops the scoreboard whenever done rises
    initial begin
        bit   dq;
        exp_t me;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dq) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done rose at cycle %0d, no run was pending", cyc);
                end else begin
                    me = sb.pop_front();
                    $display("run result: cycle=%0d sum=%0d max=%0d errs=%0d n=%0d", cyc, sum_abs_err, max_err, err_count, sample_count);
                    chk("done_cycle", cyc, me.done_cyc);
                    chk("sum_abs_err", sum_abs_err, me.sum);
                    chk("max_err", max_err, me.maxe);
                    chk("max_a", max_a, me.maxa);
                    chk("max_b", max_b, me.maxb);
                    chk("err_count", err_count, me.errc);
                    chk("sample_count", sample_count, me.scnt);
`ifdef ADD12U_ERRMON_MSE_EN
                    chk("sum_sq_err", sum_sq_err, me.sq);
`endif
                end
            end
            dq = done;
        end
    end

    initial begin
        exp_t eb;
        int   acc_cnt, t, a, b;
        bit   acc;
        rst = 1'b1; start = 1'b0; start_big = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_o = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_abs_err, 0);
        chk("rst_max", max_err, 0);
        chk("rst_errc", err_count, 0);
        chk("rst_count", sample_count, 0);
        rst = 1'b0;

        // Exact adder: no error, done 18 cycles after start
        clear_q();
        repeat (N) add_diff(0);
        drive_run(0, 1'b0);

        // Worst-case single error 0x1000
        clear_q();
        add_sample(12'hFFF, 12'h001, 0);
        repeat (N - 1) add_diff(0);
        drive_run(0, 1'b0);

        // Diffs 5,38,38,1: first 38 owns max_a/max_b
        clear_q();
        add_diff(5); add_diff(38); add_diff(38); add_diff(1);
        repeat (N - 4) add_diff(0);
        drive_run(20, 1'b0);

        // Diffs 3,4: squared sum 25
        clear_q();
        add_diff(3); add_diff(4);
        repeat (N - 2) add_diff(0);
        drive_run(0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            clear_q();
            repeat (N) add_random();
            drive_run(30, r[0]);
        end

        // Reset one cycle after an accept mid-run
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456; in_o = 13'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_count", sample_count, 0);
        chk("midrst_sum", sum_abs_err, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_sum", sum_abs_err, 0);
        chk("flush_errc", err_count, 0);
        chk("flush_max", max_err, 0);
        chk("flush_done", done, 0);

        // Continuous valid against a 4096-sample run
        clear_q();
        @(posedge clk); #1 start_big = 1'b1;
        @(posedge clk); #1 start_big = 1'b0;
        in_valid = 1'b1;
        acc_cnt  = 0;
        for (int c = 0; c < NB + 4; c++) begin
            a = int'($urandom_range(4095));
            b = int'($urandom_range(4095));
            in_a = W'(a); in_b = W'(b);
            in_o = (W+1)'(gen_o(a, b, int'($urandom_range(63))));
            acc = in_ready_big;
            @(posedge clk); #1;
            if (acc) begin
                acc_cnt++;
                add_sample(a, b, int'(in_o));
            end
        end
        in_valid = 1'b0;
        eb = model_run();
        t = 0;
        while (!done_big && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        $display("big run: accepts=%0d sum=%0d errs=%0d", acc_cnt, sum_abs_err_big, err_count_big);
        chk("big_done", done_big, 1);
        chk("big_accepts", acc_cnt, NB);
        chk("big_count", sample_count_big, NB);
        chk("big_ready", in_ready_big, 0);
        chk("big_sum", sum_abs_err_big, eb.sum);
        chk("big_errc", err_count_big, eb.errc);
        chk("big_max", max_err_big, eb.maxe);
        chk("big_max_a", max_a_big, eb.maxa);
`ifdef ADD12U_ERRMON_MSE_EN
        chk("big_sq", sum_sq_err_big, eb.sq);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
